mips_perf_trace_monitor: RTL
============================

// Module: mips_perf_trace_monitor
// PURPOSE
//  Parametrised debug/performance monitor for the single-cycle MIPS core. Sits beside the datapath
//  and taps the retired instruction word and PC. Keeps per-class instruction counters and a cycle
//  counter. Captures {pc, instr} of retired instructions into a readable trace FIFO.
//  Overflow is either circular (overwrite oldest) or stop-when-full, selected by TRACE_MODE.
// PARAMETERS
//  CNT_W       32  width of every counter; counters saturate rather than wrap
//  PC_W        32  width of captured PC
//  TRACE_DEPTH 16  trace FIFO entries; power of two, >=2
//  TRACE_MODE  0   0 = circular, overwrite oldest when full; 1 = stop when full, drop new entries
// PORTS
//  clk            in   1                 system clock, rising edge
//  rst            in   1                 asynchronous, active-high reset
//  clear          in   1                 sync clear of counters, flags and FIFO; wins over all same-cycle events
//  enable         in   1                 1 = count cycles and accept retirements
//  instr_valid    in   1                 an instruction retires this cycle
//  instr          in   32                retiring instruction word
//  pc             in   PC_W              PC of retiring instruction
//  trace_rd_en    in   1                 pop one trace entry
//  trace_rd_data  out  PC_W+32           {pc, instr} of popped entry
//  trace_rd_valid out  1                 trace_rd_data valid (1-cycle pulse)
//  trace_level    out  log2(DEPTH)+1     entries held
//  trace_empty    out  1                 level==0
//  trace_full     out  1                 level==DEPTH
//  trace_overflow out  1                 sticky: an entry was lost (overwritten or dropped)
//  cycle_count    out  CNT_W             cycles with enable=1
//  instr_count    out  CNT_W             retired non-NOP instructions
//  alu_count / mem_count / branch_count / jump_count / nop_count / unknown_count  out  CNT_W  per-class retirements
//  cnt_sat        out  1                 sticky: some counter reached 2^CNT_W-1
// BEHAVIOUR
//  - Reset (rst=1, async): all counters 0, FIFO pointers and level 0, trace_empty=1, trace_full=0.
//    trace_overflow=0, cnt_sat=0, trace_rd_valid=0, trace_rd_data=0.
//  - clear=1 at a clock edge: same state as reset. Retirements and reads in that cycle are ignored.
//  - Retirement event: instr_valid & enable & !clear.
//  - Classification (op=instr[31:26], fn=instr[5:0]); exactly one class per event:
//    NOP     instr==32'h0
//    ALU     op=0 & fn in {20,22,24,25,2A,26,00,02}h (not NOP); or op in {08,0C,0D,0A}h
//    MEM     op in {23,2B}h
//    BRANCH  op in {04,05}h
//    JUMP    op=02h
//    UNKNOWN everything else, incl. other R-type fn
//  - Counter updates: class counter +1 per event. instr_count +1 per non-NOP event.
//    cycle_count +1 per edge with enable=1. All register, visible the cycle after the event.
//  - Saturation: a counter at all-ones holds its value and sets cnt_sat; cnt_sat clears only on rst/clear.
//  - Trace write: every retirement event (NOP included) pushes {pc,instr}.
//  - Trace read: trace_rd_en & !trace_empty pops the oldest entry.
//    Data appears on trace_rd_data with trace_rd_valid=1 the next cycle (1-cycle latency).
//    trace_rd_data holds its value until the next pop.
//  - Read while empty: ignored, trace_rd_valid=0, no pointer change. No write-to-read bypass when empty.
//  - Read and write in the same cycle, not full: both happen, level unchanged.
//  - Full, write only, MODE 0: oldest entry overwritten, read pointer advances, level stays DEPTH, trace_overflow=1.
//  - Full, write only, MODE 1: write dropped, trace_overflow=1.
//  - Full, read and write in the same cycle: pop returns the oldest entry; new entry stored; level stays DEPTH; no overflow.
//  - Pointers wrap modulo DEPTH. trace_level, trace_empty and trace_full are registered and consistent with each other.
//  - enable=0: no counting or trace writes; reads still serviced.
// TESTING
//  1. rst mid-run after 10 retirements -> all outputs 0 immediately (async), trace_empty=1.
//  2. Retire ADD(0x012A4020), LW(0x8D090004), BEQ(0x11090002), J(0x08000010), NOP(0), 0xFC000000
//     -> alu/mem/branch/jump/nop/unknown=1 each, instr_count=5, trace_level=6.
//  3. DEPTH=4, MODE=0, retire pcs 0,4,...,20 then 4 pops -> data pcs 8,12,16,20; trace_overflow=1.
//  4. DEPTH=4, MODE=1, same stimulus -> pops return pcs 0,4,8,12; trace_overflow=1; level 0 after.
//  5. CNT_W=4: 20 cycles enable=1 -> cycle_count=15, cnt_sat=1. Then clear -> 0, cnt_sat=0.
//  6. Full FIFO with rd_en and instr_valid in the same cycle -> oldest returned next cycle,
//     level stays DEPTH, overflow stays 0. rd_en when empty -> trace_rd_valid stays 0.

Source files
------------

// File: rtl/mips_perf_trace_monitor.sv
// Performance/trace monitor for the single-cycle MIPS core: per-class saturating
// retirement counters, a cycle counter and a {pc, instr} trace FIFO.
module mips_perf_trace_monitor #(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          instr_valid,
  input  logic [31:0]                   instr,
  input  logic [PC_W-1:0]               pc,
  input  logic                          trace_rd_en,
  output logic [PC_W+31:0]              trace_rd_data,
  output logic                          trace_rd_valid,
  output logic [$clog2(TRACE_DEPTH):0]  trace_level,
  output logic                          trace_empty,
  output logic                          trace_full,
  output logic                          trace_overflow,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              instr_count,
  output logic [CNT_W-1:0]              alu_count,
  output logic [CNT_W-1:0]              mem_count,
  output logic [CNT_W-1:0]              branch_count,
  output logic [CNT_W-1:0]              jump_count,
  output logic [CNT_W-1:0]              nop_count,
  output logic [CNT_W-1:0]              unknown_count,
  output logic                          cnt_sat
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = PC_W + 32;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(TRACE_DEPTH);
  localparam logic CIRC = (TRACE_MODE == 0);

  localparam int CYC = 0;
  localparam int INS = 1;
  localparam int ALU = 2;
  localparam int MEM = 3;
  localparam int BRA = 4;
  localparam int JMP = 5;
  localparam int NOP = 6;
  localparam int UNK = 7;

  logic [5:0] op;
  logic [5:0] fn;
  logic       is_nop;
  logic       ev;
  logic [7:0] cls;
  logic [7:0] inc;

  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign is_nop = (instr == '0);
  assign ev     = instr_valid & enable & ~clear;

  always_comb begin
    cls = '0;
    if (is_nop) begin
      cls[NOP] = 1'b1;
    end else begin
      unique case (op)
        6'h00: begin
          if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h00, 6'h02})
            cls[ALU] = 1'b1;
          else
            cls[UNK] = 1'b1;
        end
        6'h08, 6'h0C, 6'h0D, 6'h0A: cls[ALU] = 1'b1;
        6'h23, 6'h2B:               cls[MEM] = 1'b1;
        6'h04, 6'h05:               cls[BRA] = 1'b1;
        6'h02:                      cls[JMP] = 1'b1;
        default:                    cls[UNK] = 1'b1;
      endcase
    end
  end

  always_comb begin
    inc      = ev ? cls : '0;
    inc[CYC] = enable;
    inc[INS] = ev & ~is_nop;
  end

  // Counters: index-addressed bank so saturation logic is shared by all eight.
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic             sat_hit;

  always_comb begin
    sat_hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_d[i] == '1)
        sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
      cnt_sat <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
      cnt_sat <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      if (sat_hit) cnt_sat <= 1'b1;
    end
  end

  assign cycle_count   = cnt_q[CYC];
  assign instr_count   = cnt_q[INS];
  assign alu_count     = cnt_q[ALU];
  assign mem_count     = cnt_q[MEM];
  assign branch_count  = cnt_q[BRA];
  assign jump_count    = cnt_q[JMP];
  assign nop_count     = cnt_q[NOP];
  assign unknown_count = cnt_q[UNK];

  logic [ENT_W-1:0] mem [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             mem_we;
  logic             rd_adv;
  logic             ovf_set;
  logic [LVL_W-1:0] level_d;

  // Circular overwrite on a full FIFO is a write plus a silent read-pointer advance.
  always_comb begin
    do_rd   = trace_rd_en & ~trace_empty & ~clear;
    mem_we  = ev & (~trace_full | do_rd | CIRC);
    rd_adv  = do_rd | (ev & trace_full & CIRC);
    ovf_set = ev & trace_full & ~do_rd;
    level_d = trace_level;
    unique case ({mem_we, rd_adv})
      2'b10:   level_d = trace_level + 1'b1;
      2'b01:   level_d = trace_level - 1'b1;
      default: level_d = trace_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_level    <= '0;
      trace_empty    <= 1'b1;
      trace_full     <= 1'b0;
      trace_overflow <= 1'b0;
      trace_rd_valid <= 1'b0;
      trace_rd_data  <= '0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_level    <= '0;
      trace_empty    <= 1'b1;
      trace_full     <= 1'b0;
      trace_overflow <= 1'b0;
      trace_rd_valid <= 1'b0;
      trace_rd_data  <= '0;
    end else begin
      if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      trace_level    <= level_d;
      trace_empty    <= (level_d == '0);
      trace_full     <= (level_d == DEPTH_L);
      if (ovf_set) trace_overflow <= 1'b1;
      trace_rd_valid <= do_rd;
      if (do_rd) trace_rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= {pc, instr};
  end

endmodule
